display_word_scheduler: RTL and testbench
=========================================

Name: display_word_scheduler

Overview:
- Shares the 32-bit seven-segment display word between up to NUM_SRC requesters, e.g. current nonce, hash words and status.
- In auto mode it rotates round-robin over the valid sources with a fixed dwell time.
- A golden-nonce event (urgent) pre-empts the rotation and latches on the display.
- Sits between the mining datapath and the display driver; its Word output feeds the display driver's Word input directly.

Parameters:
- NUM_SRC, 4, number of requesters (2..7).
- DWELL_CYCLES, 134217728, clk_in cycles each word is shown in auto mode (~1.34 s at 100 MHz).
- CNT_W, 28, dwell counter width; must satisfy 2**CNT_W >= DWELL_CYCLES.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- src_word  input  32*NUM_SRC  packed source words; source i occupies bits [32*i+31:32*i].
- src_valid  input  NUM_SRC  level; source i has a word to display.
- src_ack  output  NUM_SRC  one-cycle pulse on the bit of the source whose word was just captured.
- urgent_valid  input  1  one-cycle pulse; urgent_word must be captured.
- urgent_word  input  32  word to latch when urgent_valid is high.
- btn_next  input  1  debounced single-cycle pulse; advance now / release urgent.
- manual_mode  input  1  level; 1 disables dwell-based rotation.
- Word  output  32  registered display word.
- src_idx  output  3  index of the source currently displayed.
- urgent_active  output  1  high while an urgent word is held.
- word_update  output  1  one-cycle pulse on every cycle Word is loaded.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Word=0, src_idx=0, urgent_active=0, src_ack=0, word_update=0.
  - State IDLE, dwell counter=0, last_idx=NUM_SRC-1, so the first search starts at 0.
- All outputs are registered. A capture on edge N shows on Word, src_idx, src_ack and word_update after edge N.
- Pick rule (combinational): starting at last_idx+1 and wrapping modulo NUM_SRC, take the first index with src_valid=1. If only last_idx is valid, pick last_idx. If none is valid, there is no pick.
- Capture:
  - Word<=src_word[pick], src_idx<=pick, last_idx<=pick.
  - src_ack[pick] and word_update pulse for one cycle; dwell counter<=0.
- IDLE:
  - Word holds its last value.
  - Any cycle with a pick -> capture, go to SHOW.
- SHOW:
  - Dwell counter increments each cycle while manual_mode=0; it is frozen at 0 while manual_mode=1.
  - Expiry is counter==DWELL_CYCLES-1 with manual_mode=0. An expiry or a btn_next pulse, with a pick -> capture, stay in SHOW.
  - With no pick -> go to IDLE; Word holds and no pulses occur.
  - Continuously valid sources are therefore each shown for exactly DWELL_CYCLES cycles.
- URGENT:
  - Entered from any state on urgent_valid: Word<=urgent_word, urgent_active<=1, word_update pulses. src_idx and last_idx are unchanged and no src_ack pulses.
  - A further urgent_valid while in URGENT overwrites Word and pulses word_update again.
  - Dwell expiry is ignored.
  - btn_next -> urgent_active<=0, then apply the pick rule: capture and go to SHOW, or go to IDLE if there is no pick.
- Priority in the same cycle: urgent_valid > btn_next > dwell expiry.
  - btn_next coinciding with urgent_valid is discarded.
- src_valid dropping on the displayed source does not blank Word; the source is only skipped at the next advance.
- A manual_mode 1->0 transition restarts the dwell from 0.

Decomposition:
- Shared package (display_pkg):
  - State encoding IDLE=2'd0, SHOW=2'd1, URGENT=2'd2.
  - NUM_SRC_MAX=7.
  - DEFAULT_DWELL=134217728.
  - Word width constant 32.
- Sub-module display_rr_pick: purely combinational rotate-priority finder.
  - Inputs: src_valid, last_idx.
  - Outputs: pick_idx, pick_found.
  - Instantiated once.
- Top level holds the FSM, dwell counter and output registers.

Test Plan (NUM_SRC=4, DWELL_CYCLES=8, words 0x11111111..0x44444444):
- Reset: assert reset between clock edges -> all outputs 0 immediately. Hold src_valid=0 for 20 cycles after release -> Word stays 0, no pulses.
- Rotation: src_valid=4'b1111 -> src_idx sequence 0,1,2,3,0 with captures exactly 8 cycles apart; src_ack pulses 0001,0010,0100,1000; word_update pulses once per capture.
- Skip/idle: src_valid=4'b1010 -> Word alternates 0x22222222, 0x44444444. Then src_valid=0 -> Word holds 0x44444444 and no further pulses.
- Urgent: interrupt during src_idx=1 with urgent_valid and urgent_word=0xDEADBEEF -> next cycle Word=0xDEADBEEF, urgent_active=1, held for 100 cycles. btn_next -> Word=0x33333333, src_idx=2.
- Manual: manual_mode=1 -> no capture for 50 cycles. Three btn_next pulses -> exactly three captures, advancing one source each.
- Collision: urgent_valid and btn_next in the same cycle -> urgent captured, btn ignored, urgent_active=1. Then reset during URGENT -> urgent_active=0 and Word=0 immediately.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display word scheduler.
//   - State encoding for the scheduler FSM.
//   - Width and limit constants.
//   - wrap_add: modulo-N index increment used by the round-robin finder.
package display_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned IDX_W         = 3;
  localparam int unsigned NUM_SRC_MAX   = 7;
  localparam int unsigned DEFAULT_DWELL = 134217728;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    URGENT = 2'd2
  } disp_state_e;

  // (base + step) mod n, valid for base < n and step <= n.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned       step,
                                                input int unsigned       n);
    int unsigned sum;
    sum = 32'(base) + step;
    if (sum >= n) begin
      sum = sum - n;
    end
    return IDX_W'(sum);
  endfunction

endpackage

// File: rtl/display_rr_pick.sv
// Rotate-priority finder (purely combinational).
// Starting at last_idx+1 and wrapping modulo NUM_SRC, returns the first valid
// source. last_idx itself is considered last, so a lone valid last_idx is
// picked again.
// Ports:
//   src_valid  in   NUM_SRC  per-source valid level
//   last_idx   in   3        most recently captured source
//   pick_idx   out  3        chosen source (0 when pick_found is low)
//   pick_found out  1        at least one source is valid
module display_rr_pick
  import display_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] src_valid,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_found
);

  // Walk offsets 1..NUM_SRC from last_idx; first valid hit wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        if (!pick_found && src_valid[j] &&
            (wrap_add(last_idx, k, NUM_SRC) == IDX_W'(j))) begin
          pick_found = 1'b1;
          pick_idx   = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/display_word_scheduler.sv
// Shares the 32-bit seven-segment display word between NUM_SRC requesters.
// Auto mode rotates round-robin over valid sources with a fixed dwell; an
// urgent word pre-empts the rotation and is held until btn_next.
// Ports:
//   clk_in         in   1             system clock
//   reset          in   1             asynchronous active-high reset
//   src_word       in   32*NUM_SRC    packed source words, source i at [32i+31:32i]
//   src_valid      in   NUM_SRC       source i has a word to display
//   src_ack        out  NUM_SRC       one-cycle pulse on the captured source
//   urgent_valid   in   1             pulse, capture urgent_word
//   urgent_word    in   32            urgent word
//   btn_next       in   1             pulse, advance now / release urgent
//   manual_mode    in   1             level, disables dwell rotation
//   Word           out  32            registered display word
//   src_idx        out  3             source currently displayed
//   urgent_active  out  1             urgent word held
//   word_update    out  1             pulse whenever Word is loaded
module display_word_scheduler
  import display_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = DEFAULT_DWELL,
  parameter int unsigned CNT_W        = 28
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [WORD_W*NUM_SRC-1:0] src_word,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ack,
  input  logic                      urgent_valid,
  input  logic [WORD_W-1:0]         urgent_word,
  input  logic                      btn_next,
  input  logic                      manual_mode,
  output logic [WORD_W-1:0]         Word,
  output logic [IDX_W-1:0]          src_idx,
  output logic                      urgent_active,
  output logic                      word_update
);

  localparam logic [CNT_W-1:0]   EXPIRE_CNT = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_RST   = IDX_W'(NUM_SRC - 1);

  disp_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    last_idx_q, last_idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    src_idx_q, src_idx_d;
  logic                urgent_q, urgent_d;
  logic [NUM_SRC-1:0]  ack_q, ack_d;
  logic                update_q, update_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic [WORD_W-1:0]   pick_word;
  logic [NUM_SRC-1:0]  pick_ack;
  logic                expiry;

  display_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .src_valid  (src_valid),
    .last_idx   (last_idx_q),
    .pick_idx   (pick_idx),
    .pick_found (pick_found)
  );

  // Select the picked source's word and one-hot ack.
  always_comb begin
    pick_word = '0;
    pick_ack  = '0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (pick_idx == IDX_W'(j)) begin
        pick_word   = src_word[j*WORD_W +: WORD_W];
        pick_ack[j] = 1'b1;
      end
    end
  end

  assign expiry = (state_q == SHOW) && !manual_mode && (cnt_q == EXPIRE_CNT);

  // Next-state and output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    word_d     = word_q;
    src_idx_d  = src_idx_q;
    urgent_d   = urgent_q;
    ack_d      = '0;
    update_d   = 1'b0;

    if (urgent_valid) begin
      // Urgent wins over everything; a coincident btn_next is dropped.
      state_d  = URGENT;
      word_d   = urgent_word;
      urgent_d = 1'b1;
      update_d = 1'b1;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_d    = SHOW;
            word_d     = pick_word;
            src_idx_d  = pick_idx;
            last_idx_d = pick_idx;
            ack_d      = pick_ack;
            update_d   = 1'b1;
            cnt_d      = '0;
          end
        end
        SHOW: begin
          if (btn_next || expiry) begin
            if (pick_found) begin
              word_d     = pick_word;
              src_idx_d  = pick_idx;
              last_idx_d = pick_idx;
              ack_d      = pick_ack;
              update_d   = 1'b1;
              cnt_d      = '0;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (manual_mode) begin
            // Held at zero so leaving manual mode restarts a full dwell.
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        URGENT: begin
          if (btn_next) begin
            urgent_d = 1'b0;
            cnt_d    = '0;
            if (pick_found) begin
              state_d    = SHOW;
              word_d     = pick_word;
              src_idx_d  = pick_idx;
              last_idx_d = pick_idx;
              ack_d      = pick_ack;
              update_d   = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_idx_q <= LAST_RST;
      word_q     <= '0;
      src_idx_q  <= '0;
      urgent_q   <= 1'b0;
      ack_q      <= '0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      word_q     <= word_d;
      src_idx_q  <= src_idx_d;
      urgent_q   <= urgent_d;
      ack_q      <= ack_d;
      update_q   <= update_d;
    end
  end

  assign Word          = word_q;
  assign src_idx       = src_idx_q;
  assign urgent_active = urgent_q;
  assign src_ack       = ack_q;
  assign word_update   = update_q;

endmodule

// File: tb/tb_display_word_scheduler.sv
// Self-checking bench for display_word_scheduler (NUM_SRC=4, DWELL_CYCLES=8).
module tb_display_word_scheduler;

  localparam int NS = 4;
  localparam int DW = 8;

  logic          clk_in;
  logic          reset;
  logic [127:0]  src_word;
  logic [3:0]    src_valid;
  logic [3:0]    src_ack;
  logic          urgent_valid;
  logic [31:0]   urgent_word;
  logic          btn_next;
  logic          manual_mode;
  logic [31:0]   Word;
  logic [2:0]    src_idx;
  logic          urgent_active;
  logic          word_update;

  display_word_scheduler #(
    .NUM_SRC      (NS),
    .DWELL_CYCLES (DW),
    .CNT_W        (4)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .src_word      (src_word),
    .src_valid     (src_valid),
    .src_ack       (src_ack),
    .urgent_valid  (urgent_valid),
    .urgent_word   (urgent_word),
    .btn_next      (btn_next),
    .manual_mode   (manual_mode),
    .Word          (Word),
    .src_idx       (src_idx),
    .urgent_active (urgent_active),
    .word_update   (word_update)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what the display shows and for how long it has been shown.
  typedef enum int {M_BLANK, M_ROTATE, M_URGENT} mphase_e;
  mphase_e     m_phase;
  logic [31:0] m_word;
  int          m_idx;
  int          m_last;
  int          m_shown;   // cycles the current rotated word has been on display
  bit          m_urg;
  logic [3:0]  m_ack;
  bit          m_upd;

  function automatic int next_src(input int last, input logic [3:0] v);
    for (int k = 1; k <= NS; k++) begin
      if (v[(last + k) % NS]) return (last + k) % NS;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = M_BLANK; m_word = 32'h0; m_idx = 0; m_last = NS - 1;
    m_shown = 0; m_urg = 0; m_ack = 4'b0; m_upd = 0;
  endtask

  task automatic model_show(input int p);
    m_word  = src_word[p*32 +: 32];
    m_idx   = p;
    m_last  = p;
    m_ack   = 4'b0001 << p;
    m_upd   = 1;
    m_shown = 0;
    m_phase = M_ROTATE;
  endtask

  // Advance the model by one clock using the inputs sampled at that edge.
  task automatic model_step();
    int p;
    m_ack = 4'b0;
    m_upd = 0;
    if (reset) begin
      model_reset();
      return;
    end
    p = next_src(m_last, src_valid);
    if (urgent_valid) begin
      m_phase = M_URGENT; m_word = urgent_word; m_urg = 1; m_upd = 1;
    end else if (m_phase == M_BLANK) begin
      if (p >= 0) model_show(p);
    end else if (m_phase == M_ROTATE) begin
      if (btn_next || (!manual_mode && m_shown + 1 == DW)) begin
        if (p >= 0) model_show(p);
        else m_phase = M_BLANK;
      end else begin
        m_shown = manual_mode ? 0 : m_shown + 1;
      end
    end else if (btn_next) begin
      m_urg = 0;
      if (p >= 0) model_show(p);
      else m_phase = M_BLANK;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("word", Word, m_word);
    chk("src_idx", 32'(src_idx), 32'(m_idx));
    chk("urgent_active", 32'(urgent_active), 32'(m_urg));
    chk("src_ack", 32'(src_ack), 32'(m_ack));
    chk("word_update", 32'(word_update), 32'(m_upd));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_word"}, Word, 32'h0);
    chk({tag, "_idx"}, 32'(src_idx), 32'h0);
    chk({tag, "_urg"}, 32'(urgent_active), 32'h0);
    chk({tag, "_ack"}, 32'(src_ack), 32'h0);
    chk({tag, "_upd"}, 32'(word_update), 32'h0);
  endtask

  int cyc = 0;

  // One clock: model follows the sampled inputs, pulses are dropped, outputs checked.
  task automatic tick();
    @(posedge clk_in);
    cyc++;
    model_step();
    #1;
    urgent_valid = 1'b0;
    btn_next     = 1'b0;
    check_model();
  endtask

  initial begin
    int caps;
    int upd_cnt;
    int cap_cyc[5];
    int cap_idx[5];
    logic [31:0] prev_w;
    bit got44;

    reset = 1'b1; src_valid = 4'b0; urgent_valid = 1'b0; urgent_word = 32'h0;
    btn_next = 1'b0; manual_mode = 1'b0;
    src_word = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    model_reset();
    #2;
    check_zero("reset_async");
    tick(); tick();
    reset = 1'b0;

    // Idle with no valid sources.
    upd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (word_update) upd_cnt++;
    end
    chk("idle_word", Word, 32'h0);
    chk("idle_pulses", 32'(upd_cnt), 32'd0);

    // Full rotation.
    src_valid = 4'b1111;
    caps = 0;
    for (int i = 0; i < 60 && caps < 5; i++) begin
      tick();
      if (word_update) begin
        cap_cyc[caps] = cyc;
        cap_idx[caps] = int'(src_idx);
        chk("rot_ack", 32'(src_ack), 32'(4'b0001 << src_idx));
        caps++;
      end
    end
    chk("rot_caps", 32'(caps), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rot_idx", 32'(cap_idx[i]), 32'(i % NS));
      if (i > 0) chk("rot_gap", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'(DW));
    end

    // Skip invalid sources; stop right after a 0x44444444 capture.
    src_valid = 4'b1010;
    caps = 0; got44 = 0; prev_w = 32'h0;
    for (int i = 0; i < 80 && !(got44 && caps >= 3); i++) begin
      tick();
      if (word_update) begin
        if (caps > 0) chk("skip_alt", 32'(Word != prev_w), 32'd1);
        chk("skip_word", 32'((Word == 32'h22222222) || (Word == 32'h44444444)), 32'd1);
        prev_w = Word;
        got44 = (Word == 32'h44444444);
        caps++;
      end
    end
    chk("skip_end", Word, 32'h44444444);
    src_valid = 4'b0000;
    upd_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (word_update || (src_ack != 4'b0)) upd_cnt++;
    end
    chk("hold_word", Word, 32'h44444444);
    chk("hold_pulses", 32'(upd_cnt), 32'd0);

    // Urgent pre-emption while source 1 is shown.
    src_valid = 4'b1111;
    for (int i = 0; i < 40 && !(src_idx == 3'd1 && m_phase == M_ROTATE); i++) tick();
    chk("urg_pre_idx", 32'(src_idx), 32'd1);
    tick(); tick(); tick();
    urgent_valid = 1'b1; urgent_word = 32'hDEADBEEF;
    tick();
    chk("urg_word", Word, 32'hDEADBEEF);
    chk("urg_active", 32'(urgent_active), 32'd1);
    for (int i = 0; i < 100; i++) tick();
    chk("urg_held", Word, 32'hDEADBEEF);
    btn_next = 1'b1;
    tick();
    chk("urg_rel_word", Word, 32'h33333333);
    chk("urg_rel_idx", 32'(src_idx), 32'd2);
    chk("urg_rel_active", 32'(urgent_active), 32'd0);

    // Manual mode: only button presses advance.
    manual_mode = 1'b1;
    upd_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (word_update) upd_cnt++;
    end
    chk("man_idle", 32'(upd_cnt), 32'd0);
    for (int b = 0; b < 3; b++) begin
      btn_next = 1'b1;
      tick();
      if (word_update) upd_cnt++;
      chk("man_idx", 32'(src_idx), 32'((3 + b) % NS));
      for (int i = 0; i < 5; i++) begin
        tick();
        if (word_update) upd_cnt++;
      end
    end
    chk("man_caps", 32'(upd_cnt), 32'd3);
    manual_mode = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) src_valid = 4'($urandom);
      if ($urandom_range(0, 19) == 0) src_word[$urandom_range(0, 3)*32 +: 32] = $urandom;
      urgent_valid = ($urandom_range(0, 39) == 0);
      urgent_word  = $urandom;
      btn_next     = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 59) == 0) manual_mode = ~manual_mode;
      tick();
    end
    manual_mode = 1'b0;

    // Collision: urgent wins, button discarded.
    src_valid = 4'b1111;
    urgent_valid = 1'b1; urgent_word = 32'hCAFEF00D; btn_next = 1'b1;
    tick();
    chk("col_word", Word, 32'hCAFEF00D);
    chk("col_active", 32'(urgent_active), 32'd1);
    tick();
    chk("col_stay", 32'(urgent_active), 32'd1);

    // Reset in the middle of an urgent hold acts immediately.
    #2;
    reset = 1'b1;
    #1;
    check_zero("reset_urgent");
    model_reset();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
